alu_control_seq: RTL and testbench

- Parametrised, multicycle successor of the combinational ALU-control decoder in the multicycle processor datapath.
- Accepts one ALU operation code from the main control unit through a valid/ready handshake.
- Sequences the ALU, shifter and ALUOut-mux control words over 1–3 cycles, then evaluates branch flags.
- Reports completion and branch outcome back to the control unit.

---
 rtl/alu_control_seq_pkg.sv | 57 +++++
 rtl/alu_control_seq_if.sv | 37 +++
 rtl/alu_control_seq_branch_eval.sv | 23 ++
 rtl/alu_control_seq.sv | 153 +++++++++++++++
 tb/tb_alu_control_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/alu_control_seq_pkg.sv
// Shared definitions for the multicycle ALU-control sequencer: op codes,
// control-word encodings, branch classes and FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_PASSA = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SHLV  = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SRAV  = 4'd9;
    localparam logic [3:0] OP_SLTI  = 4'd10;
    localparam logic [3:0] OP_BEQ   = 4'd11;
    localparam logic [3:0] OP_BNE   = 4'd12;
    localparam logic [3:0] OP_BLE   = 4'd13;
    localparam logic [3:0] OP_BGT   = 4'd14;
    localparam logic [3:0] OP_LUI   = 4'd15;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_CMP   = 3'b111;

    localparam logic [2:0] SHF_NOP  = 3'b000;
    localparam logic [2:0] SHF_LOAD = 3'b001;
    localparam logic [2:0] SHF_SHL  = 3'b010;
    localparam logic [2:0] SHF_SHR  = 3'b011;
    localparam logic [2:0] SHF_SRA  = 3'b100;

    localparam logic [2:0] MUX_ALU = 3'b000;
    localparam logic [2:0] MUX_SHF = 3'b001;
    localparam logic [2:0] MUX_SLT = 3'b010;

    localparam logic [1:0] BRC_NONE = 2'b00;
    localparam logic [1:0] BRC_EQ   = 2'b01;
    localparam logic [1:0] BRC_NE   = 2'b10;
    localparam logic [1:0] BRC_LEGT = 2'b11;

    typedef enum logic [2:0] {
        IDLE, EXEC, SH_LOAD, SH_RUN, SH_OUT, BR_CMP, BR_EVAL, FIN
    } state_t;

    // LUI reuses the left shifter with a fixed amount.
    function automatic logic [2:0] shift_cmd(input logic [3:0] op);
        case (op)
            OP_SHL, OP_SHLV, OP_LUI: shift_cmd = SHF_SHL;
            OP_SHR:                  shift_cmd = SHF_SHR;
            OP_SRA, OP_SRAV:         shift_cmd = SHF_SRA;
            default:                 shift_cmd = SHF_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// Handshake, flag and control-word bundle between the control unit and the sequencer.
interface alu_control_seq_if #(
    parameter int unsigned OP_W         = 4,
    parameter int unsigned SHAMT_W      = 5,
    parameter int unsigned ALU_CTRL_W   = 3,
    parameter int unsigned SHIFT_CTRL_W = 3,
    parameter int unsigned MUX_W        = 3
);
    logic                    op_valid;
    logic                    op_ready;
    logic [OP_W-1:0]         alu_op;
    logic [SHAMT_W-1:0]      shamt;
    logic                    alu_zero;
    logic                    alu_gt;
    logic                    alu_lt;
    logic [ALU_CTRL_W-1:0]   ALU_control;
    logic [SHIFT_CTRL_W-1:0] SHIFTER_control;
    logic                    M_SHIFTER;
    logic [SHAMT_W-1:0]      shamt_out;
    logic [MUX_W-1:0]        M_ALUOut_control;
    logic                    UC_control;
    logic [1:0]              UC_op;
    logic                    done;
    logic                    illegal_op;

    modport master (
        output op_valid, alu_op, shamt, alu_zero, alu_gt, alu_lt,
        input  op_ready, ALU_control, SHIFTER_control, M_SHIFTER, shamt_out,
               M_ALUOut_control, UC_control, UC_op, done, illegal_op
    );

    modport slave (
        input  op_valid, alu_op, shamt, alu_zero, alu_gt, alu_lt,
        output op_ready, ALU_control, SHIFTER_control, M_SHIFTER, shamt_out,
               M_ALUOut_control, UC_control, UC_op, done, illegal_op
    );
endinterface

// File: rtl/alu_control_seq_branch_eval.sv
// Maps a captured branch op and the ALU flags to {taken, branch class}.
module branch_eval
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] op,
    input  logic       alu_zero,
    input  logic       alu_gt,
    input  logic       alu_lt,
    output logic       taken,
    output logic [1:0] uc_op
);
    always_comb begin
        taken = 1'b0;
        uc_op = BRC_NONE;
        case (op)
            OP_BEQ: begin taken = alu_zero;           uc_op = BRC_EQ;   end
            OP_BNE: begin taken = !alu_zero;          uc_op = BRC_NE;   end
            OP_BLE: begin taken = alu_lt | alu_zero;  uc_op = BRC_LEGT; end
            OP_BGT: begin taken = alu_gt;             uc_op = BRC_LEGT; end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_control_seq.sv
// Multicycle ALU-control sequencer: accepts one op per handshake and drives
// registered ALU/shifter/ALUOut control words for 1-3 cycles, then pulses done.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W         = 4,
    parameter int unsigned SHAMT_W      = 5,
    parameter int unsigned ALU_CTRL_W   = 3,
    parameter int unsigned SHIFT_CTRL_W = 3,
    parameter int unsigned MUX_W        = 3,
    parameter int unsigned LUI_SHAMT    = 16
) (
    input logic               clk,
    input logic               reset,
    alu_control_seq_if.slave  bus
);
    state_t                  state;
    logic [3:0]              op_q;
    logic [SHAMT_W-1:0]      shamt_q;
    logic                    op_illegal;
    logic                    br_taken;
    logic [1:0]              br_class;

    logic                    ready_q;
    logic [ALU_CTRL_W-1:0]   alu_ctrl_q;
    logic [SHIFT_CTRL_W-1:0] shf_ctrl_q;
    logic                    m_shifter_q;
    logic [SHAMT_W-1:0]      shamt_out_q;
    logic [MUX_W-1:0]        mux_q;
    logic                    uc_control_q;
    logic [1:0]              uc_op_q;
    logic                    done_q;
    logic                    illegal_q;

    // Only codes 0..15 exist; any set bit above bit 3 marks an illegal op.
    if (OP_W > 4) begin : g_wide_op
        assign op_illegal = |bus.alu_op[OP_W-1:4];
    end else begin : g_narrow_op
        assign op_illegal = 1'b0;
    end

    branch_eval u_branch_eval (
        .op       (op_q),
        .alu_zero (bus.alu_zero),
        .alu_gt   (bus.alu_gt),
        .alu_lt   (bus.alu_lt),
        .taken    (br_taken),
        .uc_op    (br_class)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            op_q         <= '0;
            shamt_q      <= '0;
            ready_q      <= 1'b1;
            alu_ctrl_q   <= '0;
            shf_ctrl_q   <= '0;
            m_shifter_q  <= 1'b0;
            shamt_out_q  <= '0;
            mux_q        <= '0;
            uc_control_q <= 1'b0;
            uc_op_q      <= '0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            // Each state's outputs are loaded on the edge that enters it; everything else idles at 0.
            ready_q      <= 1'b0;
            alu_ctrl_q   <= '0;
            shf_ctrl_q   <= '0;
            m_shifter_q  <= 1'b0;
            shamt_out_q  <= '0;
            mux_q        <= '0;
            uc_control_q <= 1'b0;
            uc_op_q      <= '0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.op_valid && ready_q) begin
                        ready_q <= 1'b0;
                        op_q    <= bus.alu_op[3:0];
                        shamt_q <= bus.shamt;
                        if (op_illegal) begin
                            state     <= FIN;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end else begin
                            case (bus.alu_op[3:0])
                                OP_ADD:   begin state <= EXEC; alu_ctrl_q <= ALU_CTRL_W'(ALU_ADD);   done_q <= 1'b1; end
                                OP_SUB:   begin state <= EXEC; alu_ctrl_q <= ALU_CTRL_W'(ALU_SUB);   done_q <= 1'b1; end
                                OP_AND:   begin state <= EXEC; alu_ctrl_q <= ALU_CTRL_W'(ALU_AND);   done_q <= 1'b1; end
                                OP_PASSA: begin state <= EXEC; alu_ctrl_q <= ALU_CTRL_W'(ALU_PASSA); done_q <= 1'b1; end
                                OP_SLTI: begin
                                    state      <= EXEC;
                                    alu_ctrl_q <= ALU_CTRL_W'(ALU_CMP);
                                    mux_q      <= MUX_W'(MUX_SLT);
                                    done_q     <= 1'b1;
                                end
                                OP_SHL, OP_SHLV, OP_SHR, OP_SRA, OP_SRAV, OP_LUI: begin
                                    state      <= SH_LOAD;
                                    shf_ctrl_q <= SHIFT_CTRL_W'(SHF_LOAD);
                                end
                                OP_BEQ, OP_BNE, OP_BLE, OP_BGT: begin
                                    state      <= BR_CMP;
                                    alu_ctrl_q <= ALU_CTRL_W'(ALU_CMP);
                                end
                                default: begin
                                    state  <= FIN;
                                    done_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                SH_LOAD: begin
                    state       <= SH_RUN;
                    shf_ctrl_q  <= SHIFT_CTRL_W'(shift_cmd(op_q));
                    shamt_out_q <= (op_q == OP_LUI) ? SHAMT_W'(LUI_SHAMT) : shamt_q;
                    m_shifter_q <= (op_q == OP_SHLV) || (op_q == OP_SRAV);
                end
                SH_RUN: begin
                    state  <= SH_OUT;
                    mux_q  <= MUX_W'(MUX_SHF);
                    done_q <= 1'b1;
                end
                BR_CMP: begin
                    state        <= BR_EVAL;
                    uc_control_q <= br_taken;
                    uc_op_q      <= br_class;
                    done_q       <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.op_ready         = ready_q;
    assign bus.ALU_control      = alu_ctrl_q;
    assign bus.SHIFTER_control  = shf_ctrl_q;
    assign bus.M_SHIFTER        = m_shifter_q;
    assign bus.shamt_out        = shamt_out_q;
    assign bus.M_ALUOut_control = mux_q;
    assign bus.UC_control       = uc_control_q;
    assign bus.UC_op            = uc_op_q;
    assign bus.done             = done_q;
    assign bus.illegal_op       = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized bench for alu_control_seq against a per-op cycle-sequence model.
module tb_alu_control_seq;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned SHAMT_W = 5;

    typedef struct packed {
        logic       ready;
        logic [2:0] alu;
        logic [2:0] sh;
        logic       msh;
        logic [4:0] samt;
        logic [2:0] mux;
        logic       ucc;
        logic [1:0] ucop;
        logic       done;
        logic       ill;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   is_br;
        int   op;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t pend[$];
    bit   cur_ready;

    always #5 clk = ~clk;

    alu_control_seq_if #(.OP_W(OP_W), .SHAMT_W(SHAMT_W), .ALU_CTRL_W(3),
                         .SHIFT_CTRL_W(3), .MUX_W(3)) bus ();

    alu_control_seq #(.OP_W(OP_W), .SHAMT_W(SHAMT_W), .ALU_CTRL_W(3),
                      .SHIFT_CTRL_W(3), .MUX_W(3), .LUI_SHAMT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t r;
        r.ready = bus.op_ready;
        r.alu   = bus.ALU_control;
        r.sh    = bus.SHIFTER_control;
        r.msh   = bus.M_SHIFTER;
        r.samt  = bus.shamt_out;
        r.mux   = bus.M_ALUOut_control;
        r.ucc   = bus.UC_control;
        r.ucop  = bus.UC_op;
        r.done  = bus.done;
        r.ill   = bus.illegal_op;
        return r;
    endfunction

    // Expected per-cycle outputs following a handshake on op with shift amount sa.
    task automatic push_seq(input int op, input int sa);
        exp_t e;
        e.o = '0; e.is_br = 1'b0; e.op = op;
        if (op >= 16 || op == 0) begin
            e.o.done = 1'b1;
            e.o.ill  = (op >= 16);
            pend.push_back(e);
        end else if (op <= 4 || op == 10) begin
            case (op)
                1: e.o.alu = 3'd1;
                2: e.o.alu = 3'd2;
                3: e.o.alu = 3'd3;
                4: e.o.alu = 3'd0;
                default: begin e.o.alu = 3'd7; e.o.mux = 3'd2; end
            endcase
            e.o.done = 1'b1;
            pend.push_back(e);
        end else if (op >= 11 && op <= 14) begin
            e.o.alu = 3'd7;
            pend.push_back(e);
            e.o = '0;
            e.is_br  = 1'b1;
            e.o.done = 1'b1;
            e.o.ucop = (op == 11) ? 2'd1 : (op == 12) ? 2'd2 : 2'd3;
            pend.push_back(e);
        end else begin
            e.o.sh = 3'd1;
            pend.push_back(e);
            e.o = '0;
            e.o.sh   = (op == 7) ? 3'd3 : (op == 8 || op == 9) ? 3'd4 : 3'd2;
            e.o.samt = (op == 15) ? 5'd16 : 5'(sa);
            e.o.msh  = (op == 6 || op == 9);
            pend.push_back(e);
            e.o = '0;
            e.o.mux  = 3'd1;
            e.o.done = 1'b1;
            pend.push_back(e);
        end
    endtask

    // fl < 0 randomizes flags; otherwise bits {zero, gt, lt}.
    task automatic step(input bit v, input int op, input int sa, input int fl);
        exp_t e;
        bit   z, g, l;
        if (fl < 0) begin
            z = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            l = 1'($urandom_range(0, 1));
        end else begin
            z = fl[2]; g = fl[1]; l = fl[0];
        end
        bus.op_valid = v;
        bus.alu_op   = 5'(op);
        bus.shamt    = 5'(sa);
        bus.alu_zero = z;
        bus.alu_gt   = g;
        bus.alu_lt   = l;
        @(posedge clk);
        if (v && cur_ready) push_seq(op, sa);
        #1;
        if (pend.size() > 0) begin
            e = pend.pop_front();
        end else begin
            e.o = '0; e.o.ready = 1'b1; e.is_br = 1'b0; e.op = -1;
        end
        if (e.is_br) begin
            case (e.op)
                11:      e.o.ucc = z;
                12:      e.o.ucc = !z;
                13:      e.o.ucc = l | z;
                default: e.o.ucc = g;
            endcase
        end
        check_val($sformatf("cycle op=%0d", e.op), 32'(observe()), 32'(e.o));
        cur_ready = e.o.ready;
    endtask

    initial begin
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        bus.alu_op   = '0;
        bus.shamt    = '0;
        bus.alu_zero = 1'b0;
        bus.alu_gt   = 1'b0;
        bus.alu_lt   = 1'b0;
        #2 reset = 1'b0;
        #1 check_val("reset_outputs", 32'(observe()) & 32'h000F_FFFF, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        cur_ready = 1'b1;
        repeat (2) step(1'b0, 0, 0, -1);

        step(1'b1, 1, 0, -1);  step(1'b0, 0, 0, -1);
        step(1'b1, 8, 5, -1);  repeat (3) step(1'b0, 0, 0, -1);
        step(1'b1, 15, 3, -1); repeat (3) step(1'b0, 0, 0, -1);
        step(1'b1, 5, 0, -1);  repeat (3) step(1'b0, 0, 0, -1);
        step(1'b1, 13, 0, -1); step(1'b0, 0, 0, 3'b100); step(1'b0, 0, 0, -1);
        step(1'b1, 12, 0, -1); step(1'b0, 0, 0, 3'b100); step(1'b0, 0, 0, -1);
        step(1'b1, 20, 0, -1); step(1'b0, 0, 0, -1);
        repeat (8) step(1'b1, 1, 0, -1);
        repeat (9) step(1'b1, 9, 7, -1);
        repeat (3) step(1'b0, 0, 0, -1);

        step(1'b1, 6, 9, -1);
        step(1'b0, 0, 0, -1);
        step(1'b0, 0, 0, -1);
        #2 reset = 1'b0;
        #1 check_val("reset_mid_shift", 32'(observe()) & 32'h000F_FFFF, 32'h0);
        bus.op_valid = 1'b1;
        bus.alu_op   = 5'd1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        pend.delete();
        cur_ready = 1'b1;
        repeat (3) step(1'b0, 0, 0, -1);

        repeat (500) step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 31)), -1);
        repeat (4) step(1'b0, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
